// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: turns register-bus claim reads and complete writes into
// single-cycle claim/complete strobes toward the PLIC core. It tracks one
// outstanding claimed ID per target and leaves a settle gap after each access.
//
// Optional feature macro: PLIC_COMPLETE_CHECK_EN
//   defined   - a complete must carry the ID held for that target; otherwise
//               the request is rejected with rsp_err and no strobe.
//   undefined - any in-range complete pulses the strobe and clears the held ID.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_EXEC   | registered request executes; strobes issued, id sampled
// ST_SETTLE | idle gap so the core's registered id output settles
module plic_claim_ctrl #(
    parameter int TARGETS       = 1,
    parameter int TARGET_BITS   = 1,
    parameter int SOURCES_BITS  = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [TARGET_BITS-1:0]          req_target,
    input  logic [SOURCES_BITS-1:0]         req_wdata,
    output logic                            rsp_valid,
    output logic [SOURCES_BITS-1:0]         rsp_rdata,
    output logic                            rsp_err,
    input  logic [SOURCES_BITS*TARGETS-1:0] id,
    output logic [TARGETS-1:0]              claim,
    output logic [TARGETS-1:0]              complete,
    output logic [TARGETS-1:0]              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Settle counter runs SETTLE_CYCLES-1 down to 0, one SETTLE cycle each.
    localparam logic [3:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [TARGET_BITS:0] TGT_LIM = (TARGET_BITS + 1)'(TARGETS);

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                settle_cnt;
    logic                      we_q;
    logic [TARGET_BITS-1:0]    target_q;
    logic [SOURCES_BITS-1:0]   wdata_q;
    logic [SOURCES_BITS-1:0]   held [TARGETS];
    logic                      in_range;
    logic [SOURCES_BITS-1:0]   held_sel;
    logic [SOURCES_BITS-1:0]   id_sel;
    logic                      do_claim;
    logic                      do_complete;
    logic                      err_nxt;
    logic [SOURCES_BITS-1:0]   rdata_nxt;
    logic                      unused_wdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and request-ready decode.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settle down-counter, loaded while executing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (state == ST_EXEC) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Capture the request fields on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            target_q <= '0;
            wdata_q  <= '0;
        end else if (req_valid && req_ready) begin
            we_q     <= req_we;
            target_q <= req_target;
            wdata_q  <= req_wdata;
        end
    end

    // Select the held ID and live core ID of the addressed target.
    always_comb begin
        in_range = ({1'b0, target_q} < TGT_LIM);
        held_sel = '0;
        id_sel   = '0;
        for (int t = 0; t < TARGETS; t++) begin
            if (target_q == TARGET_BITS'(t)) begin
                held_sel = held[t];
                id_sel   = id[t*SOURCES_BITS +: SOURCES_BITS];
            end
        end
    end

    // Decide the action and response of the executing request.
    always_comb begin
        do_claim    = 1'b0;
        do_complete = 1'b0;
        err_nxt     = 1'b0;
        rdata_nxt   = '0;
        if (state == ST_EXEC) begin
            if (!in_range) begin
                err_nxt = 1'b1;
            end else if (!we_q) begin
                if (held_sel != '0) begin
                    err_nxt = 1'b1;
                end else if (id_sel != '0) begin
                    do_claim  = 1'b1;
                    rdata_nxt = id_sel;
                end
            end else begin
`ifdef PLIC_COMPLETE_CHECK_EN
                if (held_sel != '0 && wdata_q == held_sel) do_complete = 1'b1;
                else                                       err_nxt     = 1'b1;
`else
                do_complete = 1'b1;
`endif
            end
        end
    end

    // The written ID only matters when completions are checked.
    assign unused_wdata = ^wdata_q;

    // Fan the single action out to the addressed target's strobe; busy mirrors held.
    always_comb begin
        claim    = '0;
        complete = '0;
        busy     = '0;
        for (int t = 0; t < TARGETS; t++) begin
            claim[t]    = do_claim    && (target_q == TARGET_BITS'(t));
            complete[t] = do_complete && (target_q == TARGET_BITS'(t));
            busy[t]     = (held[t] != '0);
        end
    end

    // Per-target outstanding ID tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < TARGETS; t++) held[t] <= '0;
        end else begin
            for (int t = 0; t < TARGETS; t++) begin
                if (claim[t])         held[t] <= id[t*SOURCES_BITS +: SOURCES_BITS];
                else if (complete[t]) held[t] <= '0;
            end
        end
    end

    // Registered response, one cycle after execution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= (state == ST_EXEC);
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
        end
    end

endmodule
